// File: rtl/bcd_down_counter.sv
// Loadable packed-BCD countdown counter with start/pause/abort control.
// Decrements once per i_tick while running, pulses o_done on reaching zero
// and pulses o_load_err when a load carries a digit above 9.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | stopped; accepts load, start (only with a non-zero count)
// S_RUN   | counting down on i_tick; i_stop pauses, load/start ignored
// S_PAUSE | count held; accepts load, start resumes, i_stop aborts to idle
module bcd_down_counter #(
    parameter int DIGITS    = 4,
    parameter int CNT_WIDTH = 4 * DIGITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_tick,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_busy,
    output logic                 o_zero,
    output logic                 o_done,
    output logic                 o_load_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_dec;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 load_ok;
    logic                 cnt_nz;
    logic                 borrow;
    logic [3:0]           digit;

    assign cnt_nz = (cnt_q != '0);

    // Reject a load if any nibble is not a decimal digit.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i_load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Ripple a borrow from digit 0 upward; a zero digit wraps to 9 and passes the borrow on.
    always_comb begin
        cnt_dec = cnt_q;
        borrow  = 1'b1;
        digit   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = cnt_q[4*i +: 4];
            if (borrow) begin
                if (digit == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                    borrow            = 1'b1;
                end else begin
                    cnt_dec[4*i +: 4] = digit - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // State, count and pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; stop beats load beats start within a cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE, S_PAUSE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_load) begin
                    if (load_ok) begin
                        cnt_d = i_load_val;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (i_start && cnt_nz) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    state_d = S_PAUSE;
                end else if (i_tick) begin
                    cnt_d = cnt_dec;
                    // Reaching zero ends the run, so RUN never sees a zero count.
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_cnt      = cnt_q;
    assign o_busy     = (state_q == S_RUN);
    assign o_zero     = ~cnt_nz;
    assign o_done     = done_q;
    assign o_load_err = err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: directed table, an asynchronous
// reset sequence, and randomized traffic against an integer-valued model.
module tb_bcd_down_counter;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_load;
    logic [W-1:0] i_load_val;
    logic         i_start;
    logic         i_stop;
    logic         i_tick;
    logic [W-1:0] o_cnt;
    logic         o_busy;
    logic         o_zero;
    logic         o_done;
    logic         o_load_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: count as a plain integer, mode as 0 idle / 1 run / 2 pause.
    int m_val;
    int m_mode;
    bit m_done;
    bit m_err;

    bcd_down_counter #(.DIGITS(DIGITS)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_tick     (i_tick),
        .o_cnt      (o_cnt),
        .o_busy     (o_busy),
        .o_zero     (o_zero),
        .o_done     (o_done),
        .o_load_err (o_load_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         st;
        logic         sp;
        logic         tk;
        logic [W-1:0] e_cnt;
        logic         e_busy;
        logic         e_done;
        logic         e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic bit bcd_valid(input logic [W-1:0] v);
        bit ok = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (((v >> (4 * i)) & 16'hF) > 9) ok = 0;
        end
        return ok;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            r = r * 10 + int'((v >> (4 * i)) & 16'hF);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int n);
        logic [W-1:0] r = '0;
        int           x = n;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | (W'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_val  = 0;
        m_mode = 0;
        m_done = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input logic ld, input logic [W-1:0] lv,
                              input logic st, input logic sp, input logic tk);
        m_done = 0;
        m_err  = 0;
        if (m_mode == 1) begin
            if (sp) begin
                m_mode = 2;
            end else if (tk) begin
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_done = 1;
                    m_mode = 0;
                end
            end
        end else begin
            if (sp) begin
                m_mode = 0;
            end else if (ld) begin
                if (bcd_valid(lv)) m_val = bcd_to_int(lv);
                else m_err = 1;
            end else if (st && m_val != 0) begin
                m_mode = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".cnt"},  32'(o_cnt),      32'(int_to_bcd(m_val)));
        chk({tag, ".busy"}, 32'(o_busy),     32'(m_mode == 1));
        chk({tag, ".zero"}, 32'(o_zero),     32'(m_val == 0));
        chk({tag, ".done"}, 32'(o_done),     32'(m_done));
        chk({tag, ".err"},  32'(o_load_err), 32'(m_err));
    endtask

    // Drive one cycle of commands, advance the model across the edge, sample #1 later.
    task automatic apply(input logic ld, input logic [W-1:0] lv,
                         input logic st, input logic sp, input logic tk);
        i_load     = ld;
        i_load_val = lv;
        i_start    = st;
        i_stop     = sp;
        i_tick     = tk;
        @(posedge i_clk);
        model_step(ld, lv, st, sp, tk);
        #1;
        i_load  = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_tick  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic addv(input logic ld, input logic [W-1:0] lv, input logic st,
                        input logic sp, input logic tk, input logic [W-1:0] ec,
                        input logic eb, input logic ed, input logic ee);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.tk = tk;
        v.e_cnt = ec; v.e_busy = eb; v.e_done = ed; v.e_err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_load     = 1'b0;
        i_load_val = '0;
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_tick     = 1'b0;
        model_reset();

        //      ld  val      st sp tk   cnt      busy done err
        addv(1, 16'h0101, 0, 0, 0, 16'h0101, 0, 0, 0);
        addv(0, 16'h0000, 1, 0, 0, 16'h0101, 1, 0, 0);
        addv(0, 16'h0000, 0, 0, 1, 16'h0100, 1, 0, 0);
        addv(0, 16'h0000, 0, 0, 1, 16'h0099, 1, 0, 0);
        addv(0, 16'h0000, 0, 0, 1, 16'h0098, 1, 0, 0);
        addv(0, 16'h0000, 0, 1, 1, 16'h0098, 0, 0, 0);
        addv(0, 16'h0000, 0, 1, 0, 16'h0098, 0, 0, 0);
        addv(0, 16'h0000, 0, 0, 1, 16'h0098, 0, 0, 0);
        addv(1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0);
        addv(0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, 0);
        addv(0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0);
        addv(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 0);
        addv(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
        addv(0, 16'h0000, 1, 0, 1, 16'h0000, 0, 0, 0);
        addv(1, 16'h00A5, 0, 0, 0, 16'h0000, 0, 0, 1);
        addv(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
        addv(1, 16'hA000, 0, 0, 0, 16'h0000, 0, 0, 1);
        addv(1, 16'h0005, 0, 0, 0, 16'h0005, 0, 0, 0);
        addv(0, 16'h0000, 1, 0, 1, 16'h0005, 1, 0, 0);
        addv(1, 16'h0050, 0, 0, 0, 16'h0005, 1, 0, 0);
        addv(1, 16'h00F0, 0, 0, 0, 16'h0005, 1, 0, 0);
        addv(0, 16'h0000, 0, 0, 1, 16'h0004, 1, 0, 0);
        addv(0, 16'h0000, 0, 1, 1, 16'h0004, 0, 0, 0);
        addv(1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0);
        addv(0, 16'h0000, 1, 0, 0, 16'h0010, 1, 0, 0);
        addv(0, 16'h0000, 0, 1, 1, 16'h0010, 0, 0, 0);
        addv(1, 16'h0007, 0, 0, 0, 16'h0007, 0, 0, 0);
        addv(0, 16'h0000, 1, 0, 0, 16'h0007, 1, 0, 0);
        addv(0, 16'h0000, 0, 0, 1, 16'h0006, 1, 0, 0);
        addv(0, 16'h0000, 0, 1, 0, 16'h0006, 0, 0, 0);
        addv(0, 16'h0000, 0, 1, 0, 16'h0006, 0, 0, 0);
        addv(0, 16'h0000, 1, 0, 0, 16'h0006, 1, 0, 0);
        addv(1, 16'h0002, 1, 1, 1, 16'h0006, 0, 0, 0);
        addv(1, 16'h0009, 1, 0, 0, 16'h0009, 0, 0, 0);
        addv(1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0);
        addv(0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0, 0);
        addv(0, 16'h0000, 0, 0, 1, 16'h0999, 1, 0, 0);

        @(negedge i_clk);
        chk("rst.cnt",  32'(o_cnt),      32'h0);
        chk("rst.busy", 32'(o_busy),     32'h0);
        chk("rst.zero", 32'(o_zero),     32'h1);
        chk("rst.done", 32'(o_done),     32'h0);
        chk("rst.err",  32'(o_load_err), 32'h0);
        i_rst_n = 1'b1;

        foreach (vecs[k]) begin
            apply(vecs[k].ld, vecs[k].lv, vecs[k].st, vecs[k].sp, vecs[k].tk);
            chk($sformatf("vec%0d.cnt", k),  32'(o_cnt),      32'(vecs[k].e_cnt));
            chk($sformatf("vec%0d.busy", k), 32'(o_busy),     32'(vecs[k].e_busy));
            chk($sformatf("vec%0d.zero", k), 32'(o_zero),     32'(vecs[k].e_cnt == '0));
            chk($sformatf("vec%0d.done", k), 32'(o_done),     32'(vecs[k].e_done));
            chk($sformatf("vec%0d.err", k),  32'(o_load_err), 32'(vecs[k].e_err));
        end

        // Asynchronous reset mid-run takes effect between clock edges.
        do_reset();
        apply(1, 16'h0003, 0, 0, 0);
        apply(0, 16'h0000, 1, 0, 0);
        apply(0, 16'h0000, 0, 0, 1);
        chk("arst.pre_cnt",  32'(o_cnt),  32'h0002);
        chk("arst.pre_busy", 32'(o_busy), 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst.cnt",  32'(o_cnt),  32'h0);
        chk("arst.busy", 32'(o_busy), 32'h0);
        chk("arst.zero", 32'(o_zero), 32'h1);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic         ld, st, sp, tk;
            logic [W-1:0] lv;
            ld = ($urandom_range(99) < 6);
            st = ($urandom_range(99) < 12);
            sp = ($urandom_range(99) < 4);
            tk = ($urandom_range(99) < 60);
            case ($urandom_range(3))
                0:       lv = int_to_bcd($urandom_range(12));
                1:       lv = int_to_bcd($urandom_range(120));
                2:       lv = int_to_bcd($urandom_range(9999));
                default: lv = W'($urandom);
            endcase
            apply(ld, lv, st, sp, tk);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
